// File: rtl/eth_mdio_master_pkg.sv
// Shared constants, state encoding and frame builder for the clause-22 MDIO master.
package eth_mdio_master_pkg;

  localparam logic [1:0] ETH_MDIO_ST    = 2'b01;
  localparam logic [1:0] ETH_MDIO_OP_RD = 2'b10;
  localparam logic [1:0] ETH_MDIO_OP_WR = 2'b01;
  localparam logic [1:0] ETH_MDIO_TA_WR = 2'b10;

  localparam int PRE_BITS  = 32;
  localparam int CMD_BITS  = 14;
  localparam int TA_BITS   = 2;
  localparam int DATA_BITS = 16;

  typedef enum logic [2:0] {
    MDIO_IDLE = 3'd0,
    MDIO_PRE  = 3'd1,
    MDIO_CMD  = 3'd2,
    MDIO_TA   = 3'd3,
    MDIO_DATA = 3'd4
  } mdio_state_t;

  // Everything after the preamble, MSB first. The TA field is only driven on writes.
  function automatic logic [31:0] mdio_frame(input logic        wr,
                                             input logic [4:0]  phy_addr,
                                             input logic [4:0]  reg_addr,
                                             input logic [15:0] wdata);
    return {ETH_MDIO_ST, (wr ? ETH_MDIO_OP_WR : ETH_MDIO_OP_RD),
            phy_addr, reg_addr, ETH_MDIO_TA_WR, wdata};
  endfunction

endpackage

// File: rtl/eth_mdio_master_mdc_gen.sv
// MDC generator: DIV clk cycles low, DIV high, with strobes one cycle ahead of each edge.
module eth_mdc_gen #(
  parameter int DIV = 20
) (
  input  logic clk,
  input  logic res,
  input  logic run,
  output logic mdc,
  output logic mdc_rise,
  output logic mdc_fall
);

  localparam logic [7:0] DIV_LAST = 8'(DIV - 1);

  logic [7:0] div_cnt_reg, div_cnt_next;
  logic       mdc_reg, mdc_next;
  logic       wrap;

  always_comb begin
    wrap         = run && (div_cnt_reg == DIV_LAST);
    div_cnt_next = 8'd0;
    mdc_next     = 1'b0;
    if (run) begin
      div_cnt_next = wrap ? 8'd0 : div_cnt_reg + 8'd1;
      mdc_next     = wrap ? ~mdc_reg : mdc_reg;
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      div_cnt_reg <= 8'd0;
      mdc_reg     <= 1'b0;
    end else begin
      div_cnt_reg <= div_cnt_next;
      mdc_reg     <= mdc_next;
    end
  end

  // Strobes are high in the cycle whose closing edge moves mdc.
  assign mdc      = mdc_reg;
  assign mdc_rise = wrap && !mdc_reg;
  assign mdc_fall = wrap && mdc_reg;

endmodule

// File: rtl/eth_mdio_master.sv
// Clause-22 MDIO master: serialises read/write frames and returns read data with a one-cycle strobe.
module eth_mdio_master
  import eth_mdio_master_pkg::*;
#(
  parameter int DIV    = 20,
  parameter bit NO_PRE = 1'b0
) (
  input  logic        clk,
  input  logic        res,
  input  logic        start,
  input  logic        wr,
  input  logic [4:0]  phy_addr,
  input  logic [4:0]  reg_addr,
  input  logic [15:0] wdata,
  output logic        busy,
  output logic [15:0] rdata,
  output logic        rdata_vld,
  output logic        mdc,
  output logic        mdo,
  output logic        mdo_en,
  input  logic        mdi
);

  mdio_state_t state_reg, state_next;
  logic [5:0]  bit_cnt_reg, bit_cnt_next;
  logic [31:0] tx_reg, tx_next;
  logic [15:0] rx_reg, rx_next;
  logic        wr_reg, wr_next;
  logic [15:0] rdata_reg, rdata_next;
  logic        rdata_vld_reg, rdata_vld_next;
  logic        mdo_reg, mdo_next;
  logic        mdo_en_reg, mdo_en_next;
  logic        last_bit;
  logic        mdc_rise, mdc_fall;

  eth_mdc_gen #(.DIV(DIV)) u_mdc_gen (
    .clk      (clk),
    .res      (res),
    .run      (state_reg != MDIO_IDLE),
    .mdc      (mdc),
    .mdc_rise (mdc_rise),
    .mdc_fall (mdc_fall)
  );

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_reg     <= MDIO_IDLE;
      bit_cnt_reg   <= 6'd0;
      tx_reg        <= 32'd0;
      rx_reg        <= 16'd0;
      wr_reg        <= 1'b0;
      rdata_reg     <= 16'd0;
      rdata_vld_reg <= 1'b0;
      mdo_reg       <= 1'b1;
      mdo_en_reg    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      bit_cnt_reg   <= bit_cnt_next;
      tx_reg        <= tx_next;
      rx_reg        <= rx_next;
      wr_reg        <= wr_next;
      rdata_reg     <= rdata_next;
      rdata_vld_reg <= rdata_vld_next;
      mdo_reg       <= mdo_next;
      mdo_en_reg    <= mdo_en_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    bit_cnt_next   = bit_cnt_reg;
    tx_next        = tx_reg;
    rx_next        = rx_reg;
    wr_next        = wr_reg;
    rdata_next     = rdata_reg;
    rdata_vld_next = 1'b0;
    mdo_next       = 1'b1;
    mdo_en_next    = 1'b0;
    last_bit       = 1'b0;

    case (state_reg)
      MDIO_PRE:  last_bit = (bit_cnt_reg == 6'(PRE_BITS - 1));
      MDIO_CMD:  last_bit = (bit_cnt_reg == 6'(CMD_BITS - 1));
      MDIO_TA:   last_bit = (bit_cnt_reg == 6'(TA_BITS - 1));
      MDIO_DATA: last_bit = (bit_cnt_reg == 6'(DATA_BITS - 1));
      default:   last_bit = 1'b0;
    endcase

    if (state_reg == MDIO_IDLE) begin
      if (start) begin
        state_next   = NO_PRE ? MDIO_CMD : MDIO_PRE;
        bit_cnt_next = 6'd0;
        tx_next      = mdio_frame(wr, phy_addr, reg_addr, wdata);
        wr_next      = wr;
      end
    end else if (mdc_fall) begin
      // The preamble is generated as constant ones; the shifter only advances after it.
      if (state_reg != MDIO_PRE) tx_next = {tx_reg[30:0], 1'b0};
      if (last_bit) begin
        bit_cnt_next = 6'd0;
        case (state_reg)
          MDIO_PRE: state_next = MDIO_CMD;
          MDIO_CMD: state_next = MDIO_TA;
          MDIO_TA:  state_next = MDIO_DATA;
          default: begin
            state_next = MDIO_IDLE;
            if (!wr_reg) begin
              rdata_next     = rx_reg;
              rdata_vld_next = 1'b1;
            end
          end
        endcase
      end else begin
        bit_cnt_next = bit_cnt_reg + 6'd1;
      end
    end

    if (mdc_rise && (state_reg == MDIO_DATA) && !wr_reg) rx_next = {rx_reg[14:0], mdi};

    // Pin values follow the next state so they only move at frame start or on an mdc fall.
    case (state_next)
      MDIO_PRE: begin
        mdo_next    = 1'b1;
        mdo_en_next = 1'b1;
      end
      MDIO_CMD: begin
        mdo_next    = tx_next[31];
        mdo_en_next = 1'b1;
      end
      MDIO_TA, MDIO_DATA: begin
        mdo_next    = wr_next ? tx_next[31] : 1'b1;
        mdo_en_next = wr_next;
      end
      default: begin
        mdo_next    = 1'b1;
        mdo_en_next = 1'b0;
      end
    endcase
  end

  assign busy      = (state_reg != MDIO_IDLE);
  assign rdata     = rdata_reg;
  assign rdata_vld = rdata_vld_reg;
  assign mdo       = mdo_reg;
  assign mdo_en    = mdo_en_reg;

endmodule

// File: tb/tb_eth_mdio_master.sv
// Self-checking bench for eth_mdio_master: captured frames and timing against a frame-level model.
module tb_eth_mdio_master;

  localparam int DIV       = 2;
  localparam int N         = 64;
  localparam int FRAME_CYC = 2 * DIV * N;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance with preamble, DIV=2
  logic        res = 1'b0, start = 1'b0, wr = 1'b0;
  logic [4:0]  phy_addr = 5'd0, reg_addr = 5'd0;
  logic [15:0] wdata = 16'd0;
  logic        busy, rdata_vld, mdc, mdo, mdo_en;
  logic [15:0] rdata;
  logic        mdi = 1'b1;

  eth_mdio_master #(.DIV(DIV), .NO_PRE(1'b0)) dut (
    .clk(clk), .res(res), .start(start), .wr(wr), .phy_addr(phy_addr), .reg_addr(reg_addr),
    .wdata(wdata), .busy(busy), .rdata(rdata), .rdata_vld(rdata_vld), .mdc(mdc), .mdo(mdo),
    .mdo_en(mdo_en), .mdi(mdi)
  );

  // Instance without preamble, DIV=1
  logic        b_res = 1'b0, b_start = 1'b0, b_wr = 1'b0;
  logic [4:0]  b_phy = 5'd0, b_reg = 5'd0;
  logic [15:0] b_wdata = 16'd0;
  logic        b_busy, b_vld, b_mdc, b_mdo, b_mdo_en;
  logic [15:0] b_rdata;
  logic        b_mdi = 1'b1;

  eth_mdio_master #(.DIV(1), .NO_PRE(1'b1)) dut_np (
    .clk(clk), .res(b_res), .start(b_start), .wr(b_wr), .phy_addr(b_phy), .reg_addr(b_reg),
    .wdata(b_wdata), .busy(b_busy), .rdata(b_rdata), .rdata_vld(b_vld), .mdc(b_mdc), .mdo(b_mdo),
    .mdo_en(b_mdo_en), .mdi(b_mdi)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Frame monitor and PHY model: bits are captured at each mdc rise
  logic [63:0] mon_bits = '0, mon_en = '0;
  int          mon_n = 0, vld_cnt = 0, viol = 0;
  logic        prev_mdc = 1'b0, prev_busy = 1'b0, prev_mdo = 1'b1, prev_en = 1'b0, prev_res = 1'b0;
  logic [15:0] phy_cur = 16'd0;
  logic [15:0] phy_q[$];

  function automatic logic phy_bit(input int idx);
    if (idx >= N - 16 && idx < N) return phy_cur[N - 1 - idx];
    return 1'b1;
  endfunction

  always @(negedge clk) begin
    if (res && prev_res) begin
      if (busy && !prev_busy) begin
        mon_n = 0;
        mon_bits = '0;
        mon_en = '0;
        if (phy_q.size() > 0) phy_cur = phy_q.pop_front();
      end else if ((mdo !== prev_mdo || mdo_en !== prev_en) && !(prev_mdc && !mdc)) begin
        viol++;
      end
      if (mdc && !prev_mdc) begin
        mon_bits = {mon_bits[62:0], mdo};
        mon_en   = {mon_en[62:0], mdo_en};
        mon_n++;
      end
      if (rdata_vld) vld_cnt++;
      mdi = phy_bit(mon_n);
    end
    prev_mdc = mdc; prev_busy = busy; prev_mdo = mdo; prev_en = mdo_en; prev_res = res;
  end

  logic [31:0] b_bits = '0;
  int          b_n = 0;
  logic        b_prev_mdc = 1'b0, b_prev_busy = 1'b0;

  always @(negedge clk) begin
    if (b_busy && !b_prev_busy) b_n = 0;
    if (b_mdc && !b_prev_mdc) begin
      b_bits = {b_bits[30:0], b_mdo};
      b_n++;
    end
    b_prev_mdc = b_mdc; b_prev_busy = b_busy;
  end

  // Reference frame from the clause-22 field layout
  function automatic logic [63:0] exp_bits(input logic w, input logic [4:0] pa, input logic [4:0] ra,
                                           input logic [15:0] wd);
    return {32'hFFFF_FFFF, 2'b01, (w ? 2'b01 : 2'b10), pa, ra, (w ? {2'b10, wd} : 18'h3FFFF)};
  endfunction

  function automatic logic [63:0] exp_en(input logic w);
    return w ? {64{1'b1}} : {{46{1'b1}}, 18'h0};
  endfunction

  typedef struct {
    logic        wr;
    logic [4:0]  pa, ra;
    logic [15:0] wd, phy, exp_rdata;
  } vec_t;

  vec_t        vecs[5];
  logic [15:0] rdata_model = 16'd0;
  int          tnum = 0;

  task automatic do_txn(input vec_t v, input bit poke);
    int k;
    int vld0;
    tnum++;
    phy_q.push_back(v.phy);
    k = 0;
    while (busy && k < 2000) begin
      @(posedge clk); #1; k++;
    end
    if (busy) check("idle_wait", 64'(busy), 64'd0);
    vld0 = vld_cnt;
    start = 1'b1; wr = v.wr; phy_addr = v.pa; reg_addr = v.ra; wdata = v.wd;
    @(posedge clk); #1;
    start = 1'b0; wr = ~v.wr;
    phy_addr = 5'($urandom); reg_addr = 5'($urandom); wdata = 16'($urandom);
    check("busy_rise", 64'(busy), 64'd1);
    k = 0;
    while (busy && k < FRAME_CYC + 10) begin
      if (poke && k == 40) start = 1'b1;
      if (poke && k == 60) start = 1'b0;
      @(posedge clk); #1; k++;
    end
    check("frame_len", 64'(k), 64'(FRAME_CYC));
    check("vld_at_end", 64'(rdata_vld), 64'(!v.wr));
    check("rdata", 64'(rdata), 64'(v.exp_rdata));
    check("end_mdc_en", 64'({mdc, mdo_en}), 64'd0);
    check("bit_count", 64'(mon_n), 64'(N));
    check("frame_bits", mon_bits, exp_bits(v.wr, v.pa, v.ra, v.wd));
    check("frame_en", mon_en, exp_en(v.wr));
    @(posedge clk); #1;
    check("vld_single", 64'(rdata_vld), 64'd0);
    check("vld_count", 64'(vld_cnt - vld0), 64'(!v.wr));
    $display("[TB] txn %0d wr=%0d phy=%h reg=%h wdata=%h rdata=%h", tnum, v.wr, v.pa, v.ra, v.wd, rdata);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int k, t1, t2, vld0;
    vec_t v;

    vecs[0] = '{1'b0, 5'h01, 5'h02, 16'h0000, 16'h7949, 16'h7949};
    vecs[1] = '{1'b1, 5'h1F, 5'h00, 16'h3100, 16'h0000, 16'h7949};
    vecs[2] = '{1'b0, 5'h1F, 5'h1F, 16'h0000, 16'h0000, 16'h0000};
    vecs[3] = '{1'b1, 5'h00, 5'h1F, 16'hFFFF, 16'h1234, 16'h0000};
    vecs[4] = '{1'b0, 5'h0A, 5'h15, 16'h0000, 16'h8001, 16'h8001};

    repeat (3) @(posedge clk);
    #1;
    check("rst_a", 64'({busy, rdata, rdata_vld, mdc, mdo, mdo_en}), 64'({1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0}));
    check("rst_b", 64'({b_busy, b_rdata, b_vld, b_mdc, b_mdo, b_mdo_en}), 64'({1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0}));
    res = 1'b1; b_res = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) begin
      do_txn(vecs[i], i == 3);
      rdata_model = vecs[i].exp_rdata;
    end

    // Reset in the middle of a read's data phase
    phy_q.push_back(16'hA5C3);
    vld0 = vld_cnt;
    start = 1'b1; wr = 1'b0; phy_addr = 5'h03; reg_addr = 5'h04;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4 * 56) @(posedge clk);
    #1;
    check("mid_busy", 64'(busy), 64'd1);
    res = 1'b0;
    #1;
    check("rst_async", 64'({mdc, mdo_en, busy, rdata_vld, mdo}), 64'({1'b0, 1'b0, 1'b0, 1'b0, 1'b1}));
    check("rst_rdata", 64'(rdata), 64'd0);
    @(posedge clk); #1;
    res = 1'b1;
    rdata_model = 16'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_no_vld", 64'(vld_cnt - vld0), 64'd0);
    $display("[TB] txn reset-abort rdata=%h", rdata);
    v = '{1'b0, 5'h03, 5'h04, 16'h0000, 16'h5AA5, 16'h5AA5};
    do_txn(v, 1'b0);
    rdata_model = v.exp_rdata;

    // Randomised transactions against the frame model
    for (int i = 0; i < 8; i++) begin
      v.wr  = 1'($urandom_range(0, 1));
      v.pa  = 5'($urandom);
      v.ra  = 5'($urandom);
      v.wd  = 16'($urandom);
      v.phy = 16'($urandom);
      v.exp_rdata = v.wr ? rdata_model : v.phy;
      do_txn(v, 1'b0);
      rdata_model = v.exp_rdata;
    end

    // Back-to-back reads with start held high
    phy_q.push_back(16'hC0DE);
    phy_q.push_back(16'h0BAD);
    start = 1'b1; wr = 1'b0; phy_addr = 5'h11; reg_addr = 5'h07;
    k = 0; t1 = -1; t2 = -1;
    while (t2 < 0 && k < 3 * FRAME_CYC) begin
      @(posedge clk); #1; k++;
      if (rdata_vld) begin
        if (t1 < 0) begin
          t1 = k;
          check("b2b_data1", 64'(rdata), 64'h0000_0000_0000_C0DE);
        end else begin
          t2 = k;
          start = 1'b0;
          check("b2b_data2", 64'(rdata), 64'h0000_0000_0000_0BAD);
        end
      end
    end
    start = 1'b0;
    check("b2b_first", 64'(t1), 64'(FRAME_CYC + 1));
    check("b2b_gap", 64'(t2 - t1), 64'(FRAME_CYC + 1));
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("b2b_stop", 64'(busy), 64'd0);
    $display("[TB] txn back-to-back t1=%0d t2=%0d rdata=%h", t1, t2, rdata);

    // No-preamble instance, DIV=1: read of all ones, then a write
    b_mdi = 1'b1;
    b_start = 1'b1; b_wr = 1'b0; b_phy = 5'h15; b_reg = 5'h0A;
    @(posedge clk); #1;
    b_start = 1'b0;
    k = 0;
    while (b_busy && k < 200) begin
      @(posedge clk); #1; k++;
    end
    check("np_busy_len", 64'(k), 64'd64);
    check("np_rdata", 64'(b_rdata), 64'h0000_0000_0000_FFFF);
    check("np_vld", 64'(b_vld), 64'd1);
    check("np_rd_bits", 64'({b_n[7:0], b_bits}), 64'({8'd32, 2'b01, 2'b10, 5'h15, 5'h0A, 18'h3FFFF}));
    $display("[TB] txn np-read rdata=%h", b_rdata);

    b_mdi = 1'b0;
    b_start = 1'b1; b_wr = 1'b1; b_phy = 5'h06; b_reg = 5'h19; b_wdata = 16'hBEEF;
    @(posedge clk); #1;
    b_start = 1'b0;
    k = 0;
    while (b_busy && k < 200) begin
      @(posedge clk); #1; k++;
    end
    check("np_wr_len", 64'(k), 64'd64);
    check("np_wr_rdata", 64'({b_vld, b_rdata}), 64'({1'b0, 16'hFFFF}));
    check("np_wr_bits", 64'({b_n[7:0], b_bits}), 64'({8'd32, 2'b01, 2'b01, 5'h06, 5'h19, 2'b10, 16'hBEEF}));
    $display("[TB] txn np-write wdata=%h", 16'hBEEF);

    check("mdo_timing", 64'(viol), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
